mem_walker_stride_nest: RTL and testbench

- Parametrised successor to the single-stride memory walker.
- Generates nested-loop addresses, addr = base + sum(idx_i * stride_i), from a stride table of NUM_LOOPS entries with signed strides.
- Exposes a valid/ready output with a 2-deep buffer and a stall back to the loop controller.
- Sits between the loop controller and the memory read/write request generator.

---
 rtl/mem_walker_pkg.sv | 24 ++
 rtl/mem_walker_out_fifo.sv | 65 ++++++
 rtl/mem_walker_stride_nest.sv | 167 ++++++++++++++++
 tb/tb_mem_walker_stride_nest.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_walker_pkg.sv
// Shared types and helpers for the nested-stride memory walker.
package mem_walker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CFG   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } walk_state_e;

  localparam int unsigned BUF_DEPTH  = 2;
  localparam int unsigned BUF_PTR_W  = 1;
  localparam int unsigned BUF_CNT_W  = 2;
  localparam int unsigned SEXT_MAX_W = 64;

  // Sign-extends the low `width` bits of value to SEXT_MAX_W bits.
  function automatic logic [SEXT_MAX_W-1:0] sign_extend(input logic [SEXT_MAX_W-1:0] value,
                                                        input int unsigned width);
    logic [SEXT_MAX_W-1:0] shifted;
    shifted = value << (SEXT_MAX_W - width);
    return $unsigned($signed(shifted) >>> (SEXT_MAX_W - width));
  endfunction

endpackage

// File: rtl/mem_walker_out_fifo.sv
// Two-entry valid/ready output buffer; a push while full is accepted only
// when the head is popped in the same cycle.
module mem_walker_out_fifo
  import mem_walker_pkg::*;
#(
  parameter int DATA_W = 48
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_valid,
  input  logic [DATA_W-1:0]    push_data,
  input  logic                 pop_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  output logic [BUF_CNT_W-1:0] count
);

  logic [DATA_W-1:0]    mem_q [BUF_DEPTH];
  logic [DATA_W-1:0]    mem_d [BUF_DEPTH];
  logic [BUF_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUF_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [BUF_CNT_W-1:0] count_q, count_d;
  logic                 full, pop, push;

  assign out_valid = count_q != '0;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = count_q == BUF_CNT_W'(BUF_DEPTH);
  assign pop       = out_valid && pop_ready;
  assign push      = push_valid && (!full || pop);

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + BUF_PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + BUF_PTR_W'(1);
    end
    count_d = count_q + BUF_CNT_W'(push) - BUF_CNT_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the storage is reset explicitly so addr_out reads 0 out of reset, not X.
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_walker_stride_nest.sv
// Nested-loop address walker: addr = base + sum(idx_i * stride_i) with signed strides.
// Optional MEM_WALKER_ZERO_STRIDE_SUPPRESS_EN: zero-stride steps push no beat.
module mem_walker_stride_nest
  import mem_walker_pkg::*;
#(
  parameter int NUM_LOOPS     = 16,
  parameter int LOOP_ID_W     = 4,
  parameter int ADDR_WIDTH    = 48,
  parameter int ADDR_STRIDE_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic                     loop_init,
  input  logic                     loop_enter,
  input  logic                     loop_index_valid,
  input  logic                     loop_exit,
  input  logic [LOOP_ID_W-1:0]     loop_index,
  input  logic                     loop_ctrl_done,
  input  logic                     cfg_addr_stride_v,
  input  logic [ADDR_STRIDE_W-1:0] cfg_addr_stride,
  output logic [ADDR_WIDTH-1:0]    addr_out,
  output logic                     addr_out_valid,
  input  logic                     addr_out_ready,
  output logic                     loop_stall,
  output logic                     busy,
  output logic                     cfg_err
);

  localparam logic [LOOP_ID_W:0] TABLE_FULL = (LOOP_ID_W + 1)'(NUM_LOOPS);

  walk_state_e              state_q, state_d;
  logic [LOOP_ID_W:0]       cnt_q, cnt_d;
  logic [ADDR_STRIDE_W-1:0] stride_q [NUM_LOOPS];
  logic [ADDR_STRIDE_W-1:0] stride_d [NUM_LOOPS];
  logic [ADDR_WIDTH-1:0]    itr_q    [NUM_LOOPS];
  logic [ADDR_WIDTH-1:0]    itr_d    [NUM_LOOPS];
  logic [ADDR_WIDTH-1:0]    cur_q, cur_d;
  logic                     err_q, err_d;

  logic                     fifo_push, fifo_pop, fifo_full;
  logic [ADDR_WIDTH-1:0]    fifo_push_data;
  logic [BUF_CNT_W-1:0]     fifo_count;
  logic                     in_range, cfg_state, step_pushes;
  logic [ADDR_WIDTH-1:0]    step_stride, step_sum;
  logic                     unused_exit;

  // Loop exit carries no address effect; it is accepted and discarded.
  assign unused_exit = loop_exit;

  assign fifo_pop    = addr_out_valid && addr_out_ready;
  assign fifo_full   = fifo_count == BUF_CNT_W'(BUF_DEPTH);
  assign cfg_state   = (state_q == ST_IDLE) || (state_q == ST_CFG);
  assign in_range    = {1'b0, loop_index} < cnt_q;
  assign step_stride = in_range
                     ? ADDR_WIDTH'(sign_extend(SEXT_MAX_W'(stride_q[loop_index]), ADDR_STRIDE_W))
                     : '0;
  // Enter+step in one cycle restarts the loop from the current address.
  assign step_sum    = (loop_enter ? cur_q : itr_q[loop_index]) + step_stride;

`ifdef MEM_WALKER_ZERO_STRIDE_SUPPRESS_EN
  assign step_pushes = step_stride != '0;
`else
  assign step_pushes = 1'b1;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stride_d       = stride_q;
    itr_d          = itr_q;
    cur_d          = cur_q;
    err_d          = err_q;
    fifo_push      = 1'b0;
    fifo_push_data = '0;

    if (cfg_addr_stride_v) begin
      if (cfg_state && (cnt_q != TABLE_FULL)) begin
        stride_d[cnt_q[LOOP_ID_W-1:0]] = cfg_addr_stride;
        cnt_d                          = cnt_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (loop_init && (state_q != ST_DRAIN)) begin
      cur_d          = base_addr;
      fifo_push      = 1'b1;
      fifo_push_data = base_addr;
    end else if (state_q == ST_RUN) begin
      if (loop_index_valid) begin
        itr_d[loop_index] = step_sum;
        cur_d             = step_sum;
        fifo_push         = step_pushes;
        fifo_push_data    = step_sum;
        if (!in_range) begin
          err_d = 1'b1;
        end
      end else if (loop_enter) begin
        itr_d[loop_index] = cur_q;
      end
    end

    if (fifo_push && fifo_full && !fifo_pop) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (loop_init)              state_d = ST_RUN;
        else if (cfg_addr_stride_v) state_d = ST_CFG;
      end
      ST_CFG: begin
        if (loop_init) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (loop_ctrl_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave on the last handshake so busy drops together with addr_out_valid.
        if ((fifo_count == '0) || ((fifo_count == BUF_CNT_W'(1)) && fifo_pop)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_LOOPS; i++) begin
        stride_q[i] <= '0;
        itr_q[i]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      err_q    <= err_d;
      stride_q <= stride_d;
      itr_q    <= itr_d;
    end
  end

  mem_walker_out_fifo #(
    .DATA_W(ADDR_WIDTH)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_valid(fifo_push),
    .push_data (fifo_push_data),
    .pop_ready (addr_out_ready),
    .out_data  (addr_out),
    .out_valid (addr_out_valid),
    .count     (fifo_count)
  );

  assign loop_stall = (fifo_count != '0) && !fifo_pop;
  assign busy       = state_q != ST_IDLE;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_mem_walker_stride_nest.sv
// Randomised and directed bench for mem_walker_stride_nest with a queue scoreboard
// fed by a behavioural walker model.
module tb_mem_walker_stride_nest;

  localparam int NL = 16;
  localparam int LW = 4;
  localparam int AW = 48;
  localparam int SW = 16;

  localparam int M_IDLE  = 0;
  localparam int M_CFG   = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] base_addr;
  logic          loop_init, loop_enter, loop_index_valid, loop_exit, loop_ctrl_done;
  logic [LW-1:0] loop_index;
  logic          cfg_addr_stride_v;
  logic [SW-1:0] cfg_addr_stride;
  logic [AW-1:0] addr_out;
  logic          addr_out_valid, addr_out_ready;
  logic          loop_stall, busy, cfg_err;

  always #5 clk = ~clk;

  mem_walker_stride_nest dut (
    .clk              (clk),
    .reset            (reset),
    .base_addr        (base_addr),
    .loop_init        (loop_init),
    .loop_enter       (loop_enter),
    .loop_index_valid (loop_index_valid),
    .loop_exit        (loop_exit),
    .loop_index       (loop_index),
    .loop_ctrl_done   (loop_ctrl_done),
    .cfg_addr_stride_v(cfg_addr_stride_v),
    .cfg_addr_stride  (cfg_addr_stride),
    .addr_out         (addr_out),
    .addr_out_valid   (addr_out_valid),
    .addr_out_ready   (addr_out_ready),
    .loop_stall       (loop_stall),
    .busy             (busy),
    .cfg_err          (cfg_err)
  );

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] exp_q  [$];
  logic [AW-1:0] got_q  [$];
  logic [AW-1:0] want_q [$];

  // Behavioural model of the walker.
  int            m_state, m_cnt, m_occ;
  logic [SW-1:0] m_stride [NL];
  logic [AW-1:0] m_itr    [NL];
  logic [AW-1:0] m_cur;
  bit            m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, req);
    end
  endtask

  task automatic m_reset();
    m_state = M_IDLE;
    m_cnt   = 0;
    m_occ   = 0;
    m_cur   = '0;
    m_err   = 1'b0;
    for (int i = 0; i < NL; i++) begin
      m_stride[i] = '0;
      m_itr[i]    = '0;
    end
    exp_q.delete();
  endtask

  // Applies the effect of the coming clock edge, given the inputs now driven.
  task automatic model_edge();
    bit            pop, do_push;
    int            old_occ, i;
    longint        s;
    logic [AW-1:0] beat, n;
    old_occ = m_occ;
    pop     = (m_occ > 0) && addr_out_ready;
    do_push = 1'b0;
    beat    = '0;
    i       = int'(loop_index);
    if (cfg_addr_stride_v) begin
      if ((m_state == M_IDLE || m_state == M_CFG) && m_cnt < NL) begin
        m_stride[m_cnt] = cfg_addr_stride;
        m_cnt++;
      end else begin
        m_err = 1'b1;
      end
    end
    if (loop_init && m_state != M_DRAIN) begin
      m_cur   = base_addr;
      beat    = base_addr;
      do_push = 1'b1;
    end else if (m_state == M_RUN && loop_index_valid) begin
      s = (i < m_cnt) ? longint'($signed(m_stride[i])) : 64'sd0;
      if (i >= m_cnt) m_err = 1'b1;
      n = (loop_enter ? m_cur : m_itr[i]) + AW'(s);
      m_itr[i] = n;
      m_cur    = n;
      beat     = n;
`ifdef MEM_WALKER_ZERO_STRIDE_SUPPRESS_EN
      do_push = (s != 0);
`else
      do_push = 1'b1;
`endif
    end else if (m_state == M_RUN && loop_enter) begin
      m_itr[i] = m_cur;
    end
    if (do_push) begin
      if (m_occ == 2 && !pop) m_err = 1'b1;
      else begin
        exp_q.push_back(beat);
        m_occ++;
      end
    end
    if (pop) m_occ--;
    case (m_state)
      M_IDLE:  if (loop_init) m_state = M_RUN; else if (cfg_addr_stride_v) m_state = M_CFG;
      M_CFG:   if (loop_init) m_state = M_RUN;
      M_RUN:   if (loop_ctrl_done) m_state = M_DRAIN;
      default: if (old_occ == 0 || (old_occ == 1 && pop)) begin
                 m_state = M_IDLE;
                 m_cnt   = 0;
               end
    endcase
  endtask

  task automatic idle_inputs();
    loop_init         = 1'b0;
    loop_enter        = 1'b0;
    loop_index_valid  = 1'b0;
    loop_exit         = 1'b0;
    loop_ctrl_done    = 1'b0;
    cfg_addr_stride_v = 1'b0;
  endtask

  // One clock: check status outputs mid-cycle, advance the model, return at posedge+1.
  task automatic cycle();
    @(negedge clk);
    check("valid", 64'(addr_out_valid), 64'(m_occ > 0));
    check("stall", 64'(loop_stall), 64'(m_occ > 0 && !addr_out_ready));
    check("busy", 64'(busy), 64'(m_state != M_IDLE));
    check("cfg_err", 64'(cfg_err), 64'(m_err));
    model_edge();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic cfg_write(input logic [SW-1:0] v);
    cfg_addr_stride_v = 1'b1;
    cfg_addr_stride   = v;
    cycle();
  endtask

  task automatic do_init(input logic [AW-1:0] b);
    base_addr = b;
    loop_init = 1'b1;
    cycle();
  endtask

  task automatic do_ev(input bit ent, input bit stp, input int idx);
    loop_index       = LW'(idx);
    loop_enter       = ent;
    loop_index_valid = stp;
    cycle();
  endtask

  task automatic finish_walk(input string tag);
    addr_out_ready = 1'b1;
    loop_ctrl_done = 1'b1;
    cycle();
    for (int k = 0; k < 20 && busy; k++) cycle();
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(want_q.size()));
    for (int k = 0; k < want_q.size(); k++) begin
      check($sformatf("%s_beat%0d", tag, k), (k < got_q.size()) ? 64'(got_q[k]) : '1, 64'(want_q[k]));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Scoreboard monitor: a handshake seen mid-cycle completes on the next edge.
  always @(negedge clk) begin
    if (reset && addr_out_valid && addr_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_unexpected actual=0x%0h expected=none", addr_out);
      end else begin
        check("beat", 64'(addr_out), 64'(exp_q.pop_front()));
      end
      got_q.push_back(addr_out);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, r, idx;
    reset           = 1'b0;
    addr_out_ready  = 1'b1;
    base_addr       = '0;
    loop_index      = '0;
    cfg_addr_stride = '0;
    idle_inputs();
    m_reset();
    #1;
    check("rst_addr", 64'(addr_out), 64'd0);
    check("rst_valid", 64'(addr_out_valid), 64'd0);
    check("rst_stall", 64'(loop_stall), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(cfg_err), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Two-level nest: slot0 = 64, slot1 = 4.
    got_q.delete();
    cfg_write(16'd64);
    cfg_write(16'd4);
    do_init(48'h1000);
    do_ev(1, 0, 0);
    do_ev(1, 0, 1);
    repeat (3) do_ev(0, 1, 1);
    do_ev(0, 1, 0);
    do_ev(1, 0, 1);
    do_ev(0, 1, 1);
    finish_walk("nest");
    want_q = {48'h1000, 48'h1004, 48'h1008, 48'h100C, 48'h1040, 48'h1044};
    check_log("nest");

    // Negative stride wrapping below zero.
    got_q.delete();
    cfg_write(16'hFFF8);
    do_init(48'h4);
    do_ev(1, 0, 0);
    do_ev(0, 1, 0);
    do_ev(0, 1, 0);
    finish_walk("wrap");
    want_q = {48'h4, 48'hFFFF_FFFF_FFFC, 48'hFFFF_FFFF_FFF4};
    check_log("wrap");
    check("wrap_err", 64'(cfg_err), 64'd0);

    // Back-pressure: third push dropped, buffered beats survive through DRAIN.
    got_q.delete();
    addr_out_ready = 1'b0;
    cfg_write(16'h10);
    do_init(48'h2000);
    check("bp_stall", 64'(loop_stall), 64'd1);
    do_ev(1, 1, 0);
    do_ev(0, 1, 0);
    check("bp_drop_err", 64'(cfg_err), 64'd1);
    loop_ctrl_done = 1'b1;
    cycle();
    repeat (3) cycle();
    check("bp_drain_busy", 64'(busy), 64'd1);
    finish_walk("bp");
    want_q = {48'h2000, 48'h2010};
    check_log("bp");

    // Step on a loop without a loaded stride.
    do_reset();
    got_q.delete();
    cfg_write(16'd1);
    cfg_write(16'd2);
    cfg_write(16'd3);
    do_init(48'h3000);
    do_ev(1, 1, 5);
    check("oor_err", 64'(cfg_err), 64'd1);
    finish_walk("oor");
    want_q = {48'h3000, 48'h3000};
    check_log("oor");

    // Stride table overflow, then reset during a walk.
    do_reset();
    for (int k = 0; k < NL; k++) cfg_write(SW'(k + 1));
    check("full_err0", 64'(cfg_err), 64'd0);
    cfg_write(16'h7);
    check("full_err1", 64'(cfg_err), 64'd1);
    addr_out_ready = 1'b0;
    do_init(48'h5000);
    check("mid_valid_pre", 64'(addr_out_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_valid", 64'(addr_out_valid), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_err", 64'(cfg_err), 64'd0);
    m_reset();
    idle_inputs();
    @(posedge clk);
    #1;
    reset          = 1'b1;
    addr_out_ready = 1'b1;

    // Zero-stride steps.
    got_q.delete();
    cfg_write(16'd0);
    cfg_write(16'd4);
    do_init(48'h6000);
    do_ev(1, 0, 0);
    do_ev(1, 0, 1);
    do_ev(0, 1, 0);
    do_ev(0, 1, 1);
    finish_walk("zero");
`ifdef MEM_WALKER_ZERO_STRIDE_SUPPRESS_EN
    want_q = {48'h6000, 48'h6004};
`else
    want_q = {48'h6000, 48'h6000, 48'h6004};
`endif
    check_log("zero");

    // Randomised walks.
    do_reset();
    for (int w = 0; w < 4; w++) begin
      n = $urandom_range(1, NL);
      addr_out_ready = 1'b1;
      for (int k = 0; k < n; k++) cfg_write(SW'($urandom));
      do_init(AW'({$urandom(), $urandom()}));
      for (int c = 0; c < 80; c++) begin
        r   = $urandom_range(0, 99);
        idx = $urandom_range(0, n);
        if (idx > NL - 1) idx = NL - 1;
        addr_out_ready = ($urandom_range(0, 3) != 0);
        loop_index     = LW'(idx);
        if (r < 5) begin
          base_addr = AW'({$urandom(), $urandom()});
          loop_init = 1'b1;
        end else if (r < 8) begin
          cfg_addr_stride_v = 1'b1;
          cfg_addr_stride   = SW'($urandom);
        end else if (r < 30) begin
          loop_enter = (idx < n);
        end else if (r < 45) begin
          loop_enter       = 1'b1;
          loop_index_valid = 1'b1;
        end else if (r < 80) begin
          loop_index_valid = 1'b1;
        end else begin
          loop_exit = 1'b1;
        end
        cycle();
      end
      finish_walk($sformatf("rnd%0d", w));
      check($sformatf("rnd%0d_sb_empty", w), 64'(exp_q.size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
